// File: rtl/dprf_mp_pkg.sv
// Shared types and helpers for the dprf_mp register file.
package dprf_mp_pkg;

   // Sequencer states: sweeping the array, or serving user traffic
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } dprf_state_e;

   // Address width for a given depth; never narrower than one bit
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dprf_mp_clr_seq.sv
// Clear sequencer: sweeps every entry after reset or on request and
// reports readiness once the last entry has been written.
module dprf_mp_clr_seq
   import dprf_mp_pkg::*;
#(
   parameter  int unsigned DEPTH = 32,
   localparam int unsigned AW    = addr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          sweep_we_c,
   output logic [AW-1:0] sweep_addr,
   output logic          ready
);

   dprf_state_e   state;
   dprf_state_e   state_d;
   logic [AW-1:0] clr_cnt;
   logic [AW-1:0] clr_cnt_d;
   logic          ready_d;

   // State, sweep counter and ready flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         state   <= state_d;
         clr_cnt <= clr_cnt_d;
         ready   <= ready_d;
      end
   end

   // Next state: walk the counter through every entry, restart on clr_req
   always_comb begin
      state_d    = state;
      clr_cnt_d  = clr_cnt;
      sweep_we_c = 1'b0;
      case (state)
         CLEAR: begin
            sweep_we_c = 1'b1;
            clr_cnt_d  = clr_cnt + AW'(1);
            if (clr_cnt == AW'(DEPTH - 1)) begin
               state_d   = READY;
               clr_cnt_d = '0;
            end
         end
         READY: begin
            if (clr_req) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
         end
      endcase
      ready_d = (state_d == READY);
   end

   assign sweep_addr = clr_cnt;

endmodule

// File: rtl/dprf_mp.sv
// Parametrised register file: one synchronous write port, NRD asynchronous
// read ports, hardware clear sweep after reset or on request.
// Optional macro DPRF_MP_BYPASS_EN: same-cycle write-to-read forwarding.
module dprf_mp
   import dprf_mp_pkg::*;
#(
   parameter  int unsigned      DEPTH       = 32,
   parameter  int unsigned      WIDTH       = 32,
   parameter  int unsigned      NRD         = 2,
   parameter  logic [WIDTH-1:0] CLEAR_VAL   = '0,
   parameter  int unsigned      ZERO_ENTRY0 = 1,
   localparam int unsigned      AW          = addr_w(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_req,
   output logic                      ready,
   output logic                      wr_drop,
   input  logic                      wen,
   input  logic [AW-1:0]             waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [NRD-1:0][AW-1:0]    raddr,
   output logic [NRD-1:0][WIDTH-1:0] rdata
);

   localparam bit ZE0 = (ZERO_ENTRY0 != 0);

   (* ram_style = "distributed", syn_ramstyle = "distributed_ram" *)
   logic [WIDTH-1:0] rf [DEPTH];

   logic          sweep_we_c;
   logic [AW-1:0] sweep_addr;
   logic          user_we_c;
   logic          wr_drop_c;

   dprf_mp_clr_seq #(
      .DEPTH (DEPTH)
   ) u_clr_seq (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .sweep_we_c (sweep_we_c),
      .sweep_addr (sweep_addr),
      .ready      (ready)
   );

   // A clear request wins over a user write in the same cycle; entry 0
   // writes vanish silently when it is hardwired to zero
   assign user_we_c = wen & ready & ~clr_req & ~(ZE0 && (waddr == '0));
   assign wr_drop_c = wen & (~ready | clr_req);

   // Storage: sweep writes take priority, user writes only when ready
   always_ff @(posedge clk) begin
      if (sweep_we_c) begin
         rf[sweep_addr] <= CLEAR_VAL;
      end else if (user_we_c) begin
         rf[waddr] <= wdata;
      end
   end

   // One-cycle pulse for each discarded write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_drop <= 1'b0;
      end else begin
         wr_drop <= wr_drop_c;
      end
   end

   // Read muxes: zero entry overrides the sweep mask, which overrides data
   always_comb begin
      rdata = '0;
      for (int i = 0; i < int'(NRD); i++) begin
         rdata[i] = rf[raddr[i]];
`ifdef DPRF_MP_BYPASS_EN
         if (user_we_c && (raddr[i] == waddr)) begin
            rdata[i] = wdata;
         end
`endif
         if (!ready) begin
            rdata[i] = CLEAR_VAL;
         end
         if (ZE0 && (raddr[i] == '0)) begin
            rdata[i] = '0;
         end
      end
   end

endmodule

// File: tb/tb_dprf_mp.sv
// Self-checking bench for dprf_mp: directed corner cases, a vector table and
// random traffic against an array-level reference model.
module tb_dprf_mp;

   logic clk;
   logic rst;

   // Instance 0: 32 x 32, two ports, no zero entry
   logic            clr0, wen0, ready0, drop0;
   logic [4:0]      waddr0;
   logic [31:0]     wdata0;
   logic [1:0][4:0]  raddr0;
   logic [1:0][31:0] rdata0;

   // Instance 1: 64 x 8, four ports, zero entry
   logic            clr1, wen1, ready1, drop1;
   logic [5:0]      waddr1;
   logic [7:0]      wdata1;
   logic [3:0][5:0] raddr1;
   logic [3:0][7:0] rdata1;

   int nchk;
   int nfail;

   dprf_mp #(
      .DEPTH(32), .WIDTH(32), .NRD(2), .CLEAR_VAL(32'hDEAD_BEEF), .ZERO_ENTRY0(0)
   ) u0 (
      .clk(clk), .rst(rst), .clr_req(clr0), .ready(ready0), .wr_drop(drop0),
      .wen(wen0), .waddr(waddr0), .wdata(wdata0), .raddr(raddr0), .rdata(rdata0)
   );

   dprf_mp #(
      .DEPTH(64), .WIDTH(8), .NRD(4), .CLEAR_VAL(8'hA5), .ZERO_ENTRY0(1)
   ) u1 (
      .clk(clk), .rst(rst), .clr_req(clr1), .ready(ready1), .wr_drop(drop1),
      .wen(wen1), .waddr(waddr1), .wdata(wdata1), .raddr(raddr1), .rdata(rdata1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int dep(input int k);
      return (k == 0) ? 32 : 64;
   endfunction

   function automatic logic [31:0] cv(input int k);
      return (k == 0) ? 32'hDEAD_BEEF : 32'h0000_00A5;
   endfunction

   function automatic bit ze(input int k);
      return (k == 1);
   endfunction

   logic [31:0] mem [2][64];
   int          busy [2];   // cycles of sweep still to go; 0 = ready
   logic        edrop [2];
   logic        mw [2];
   int          ma [2];
   logic [31:0] md [2];
   logic        mc [2];

   always_comb begin
      mw[0] = wen0; ma[0] = int'(waddr0); md[0] = wdata0;      mc[0] = clr0;
      mw[1] = wen1; ma[1] = int'(waddr1); md[1] = 32'(wdata1); mc[1] = clr1;
   end

   // A sweep is modelled as a countdown; contents become CLEAR_VAL when it ends
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            busy[k]  <= dep(k);
            edrop[k] <= 1'b0;
         end else if (busy[k] > 0) begin
            busy[k]  <= busy[k] - 1;
            edrop[k] <= mw[k];
            if (busy[k] == 1) begin
               for (int i = 0; i < dep(k); i++) mem[k][i] <= cv(k);
            end
         end else if (mc[k]) begin
            busy[k]  <= dep(k);
            edrop[k] <= mw[k];
         end else begin
            edrop[k] <= 1'b0;
            if (mw[k] && !(ze(k) && ma[k] == 0)) mem[k][ma[k]] <= md[k];
         end
      end
   end

   function automatic logic [31:0] exp_rd(input int k, input int a);
      if (ze(k) && a == 0) return 32'h0;
      if (busy[k] != 0) return cv(k);
`ifdef DPRF_MP_BYPASS_EN
      if (mw[k] && !mc[k] && a == ma[k] && !(ze(k) && a == 0)) return md[k];
`endif
      return mem[k][a];
   endfunction

   // ---------------- checking helpers ----------------
   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk();
      #1;
      cmp("ready0", 32'(ready0), 32'(busy[0] == 0));
      cmp("wr_drop0", 32'(drop0), 32'(edrop[0]));
      cmp("ready1", 32'(ready1), 32'(busy[1] == 0));
      cmp("wr_drop1", 32'(drop1), 32'(edrop[1]));
      for (int i = 0; i < 2; i++)
         cmp($sformatf("rdata0[%0d]", i), rdata0[i], exp_rd(0, int'(raddr0[i])));
      for (int i = 0; i < 4; i++)
         cmp($sformatf("rdata1[%0d]", i), 32'(rdata1[i]), exp_rd(1, int'(raddr1[i])));
   endtask

   task automatic wait_ready(input int k, output int n);
      n = 0;
      do begin
         cyc();
         chk();
         n++;
      end while (!((k == 0) ? ready0 : ready1) && n < 200);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int n;
      nchk = 0;
      nfail = 0;

      tbl[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd3,  5'd4,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[1] = '{1'b1, 5'd7,  32'hAAAA_5555, 5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678};
      tbl[2] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  32'hAAAA_5555, 32'h1234_5678};
      tbl[3] = '{1'b1, 5'd5,  32'h0,         5'd7,  5'd31, 32'hAAAA_5555, 32'hDEAD_BEEF};
      tbl[4] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'h0,         32'hDEAD_BEEF};
      tbl[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0,  5'd1,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[6] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

      rst = 1'b1;
      clr0 = 1'b0; wen0 = 1'b0; waddr0 = '0; wdata0 = '0; raddr0 = '0;
      clr1 = 1'b0; wen1 = 1'b0; waddr1 = '0; wdata1 = '0; raddr1 = '0;

      // Reset state
      repeat (3) cyc();
      raddr0 = {5'd9, 5'd17};
      chk();
      cmp("rst_ready0", 32'(ready0), 32'h0);
      cmp("rst_drop0", 32'(drop0), 32'h0);
      cmp("rst_rdata0", rdata0[0], 32'hDEAD_BEEF);

      // Sweep length after reset release, then every entry holds CLEAR_VAL
      rst = 1'b0;
      wait_ready(0, n);
      cmp("sweep_len_rst", 32'(n), 32'd32);
      for (int a = 0; a < 32; a++) begin
         cyc();
         raddr0 = {5'(a), 5'(31 - a)};
         chk();
         cmp("swept_p0", rdata0[0], 32'hDEAD_BEEF);
         cmp("swept_p1", rdata0[1], 32'hDEAD_BEEF);
      end

      // Write to 5: old data within the write cycle unless forwarding is on
      cyc();
      wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678; raddr0 = {5'd5, 5'd5};
      chk();
`ifdef DPRF_MP_BYPASS_EN
      cmp("wcycle_p0", rdata0[0], 32'h1234_5678);
      cmp("wcycle_p1", rdata0[1], 32'h1234_5678);
`else
      cmp("wcycle_p0", rdata0[0], 32'hDEAD_BEEF);
      cmp("wcycle_p1", rdata0[1], 32'hDEAD_BEEF);
`endif
      cyc();
      wen0 = 1'b0;
      chk();
      cmp("after_w_p0", rdata0[0], 32'h1234_5678);
      cmp("after_w_p1", rdata0[1], 32'h1234_5678);

      // Vector table in READY
      foreach (tbl[v]) begin
         cyc();
         wen0 = tbl[v].wen; waddr0 = tbl[v].wa; wdata0 = tbl[v].wd;
         raddr0 = {tbl[v].ra1, tbl[v].ra0};
         chk();
         cmp($sformatf("tbl%0d_p0", v), rdata0[0], tbl[v].e0);
         cmp($sformatf("tbl%0d_p1", v), rdata0[1], tbl[v].e1);
         cmp($sformatf("tbl%0d_drop", v), 32'(drop0), 32'h0);
      end
      cyc();
      wen0 = 1'b0;

      // Write during the sweep is dropped with a single pulse
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (10) begin cyc(); chk(); end
      wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h5555_5555;
      cyc();
      wen0 = 1'b0;
      chk();
      cmp("sweep_drop_hi", 32'(drop0), 32'h1);
      cyc();
      chk();
      cmp("sweep_drop_lo", 32'(drop0), 32'h0);
      wait_ready(0, n);
      cyc();
      raddr0 = {5'd3, 5'd3};
      chk();
      cmp("sweep_drop_entry", rdata0[0], 32'hDEAD_BEEF);

      // clr_req with a simultaneous write: clear wins
      cyc();
      wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h1111_2222;
      cyc();
      wen0 = 1'b0; raddr0 = {5'd12, 5'd12};
      chk();
      cmp("pre_clr_entry", rdata0[0], 32'h1111_2222);
      cyc();
      clr0 = 1'b1; wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h3333_4444;
      chk();
      cyc();
      clr0 = 1'b0; wen0 = 1'b0;
      chk();
      cmp("clr_ready_lo", 32'(ready0), 32'h0);
      cmp("clr_drop", 32'(drop0), 32'h1);
      wait_ready(0, n);
      cmp("sweep_len_clr", 32'(n), 32'd32);
      cyc();
      raddr0 = {5'd0, 5'd12};
      chk();
      cmp("clr_entry", rdata0[0], 32'hDEAD_BEEF);

      // Reset mid-sweep restarts the sweep from zero
      cyc();
      wen0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h7777_7777;
      cyc();
      wen0 = 1'b0; rst = 1'b1; raddr1 = {6'd3, 6'd2, 6'd1, 6'd0};
      cyc();
      rst = 1'b0;
      repeat (17) begin cyc(); chk(); end
      rst = 1'b1;
      cyc();
      chk();
      cmp("midrst_ready", 32'(ready0), 32'h0);
      rst = 1'b0;
      wait_ready(0, n);
      cmp("sweep_len_midrst", 32'(n), 32'd32);
      cyc();
      raddr0 = {5'd20, 5'd20};
      chk();
      cmp("midrst_entry", rdata0[0], 32'hDEAD_BEEF);

      // Zero entry on instance 1
      wait_ready(1, n);
      cmp("sweep1_done", 32'(ready1), 32'h1);
      cyc();
      wen1 = 1'b1; waddr1 = 6'd0; wdata1 = 8'hFF; raddr1 = '0;
      chk();
      cyc();
      wen1 = 1'b0;
      chk();
      for (int i = 0; i < 4; i++) cmp($sformatf("ze_rd%0d", i), 32'(rdata1[i]), 32'h0);
      cmp("ze_nodrop", 32'(drop1), 32'h0);
      cyc();
      wen1 = 1'b1; waddr1 = 6'd1; wdata1 = 8'hFF;
      chk();
      cyc();
      wen1 = 1'b0; raddr1 = {6'd1, 6'd1, 6'd1, 6'd1};
      chk();
      for (int i = 0; i < 4; i++) cmp($sformatf("e1_rd%0d", i), 32'(rdata1[i]), 32'hFF);

      // Random traffic on both instances
      for (int c = 0; c < 800; c++) begin
         cyc();
         wen0 = 1'($urandom_range(0, 1));
         waddr0 = 5'($urandom);
         wdata0 = $urandom;
         raddr0 = {5'($urandom), 5'($urandom)};
         clr0 = ($urandom_range(0, 99) == 0);
         wen1 = 1'($urandom_range(0, 1));
         waddr1 = 6'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         wdata1 = 8'($urandom);
         raddr1 = {6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom_range(0, 2))};
         clr1 = ($urandom_range(0, 149) == 0);
         chk();
      end
      cyc();
      wen0 = 1'b0; clr0 = 1'b0; wen1 = 1'b0; clr1 = 1'b0;
      chk();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
